pkt_mem_nport: RTL and testbench
================================

PKT_MEM_NPORT -- requirements
Module: pkt_mem_nport

Interface
REQ-001 SHALL have parameter pPORTS, default 4, meaning the number of ingress ports, each with its own region (range 2..16).
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, meaning the bits per memory word.
REQ-003 SHALL have parameter pREGION_DEPTH, default 1536, meaning the words per port region; local AW = $clog2(pPORTS*pREGION_DEPTH), PW = $clog2(pPORTS), OW = $clog2(pREGION_DEPTH+1).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port i_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have write-side inputs: i_wr_en 1 (data beat valid); i_port_num PW (source port); i_data pDATA_WIDTH; i_sof 1; i_eof 1; i_extra_byte 2 (valid-byte code of the last word).
REQ-007 SHALL have input i_abort, pPORTS bits: per-port request to discard the open frame.
REQ-008 SHALL have release inputs: i_free_en 1; i_free_port PW; i_free_words OW (words returned by the egress side).
REQ-009 SHALL have read inputs i_rd_en 1 and i_rd_addr AW, and output o_rd_data pDATA_WIDTH.
REQ-010 SHALL have descriptor outputs: o_desc_valid 1; o_desc_port PW; o_desc_start AW; o_desc_end AW; o_desc_extra 2.
REQ-011 SHALL have outputs o_drop (pPORTS bits, one-cycle pulse per dropped frame) and o_full (pPORTS bits, region occupancy == pREGION_DEPTH).

Function
REQ-012 SHALL map port p to absolute addresses p*pREGION_DEPTH .. (p+1)*pREGION_DEPTH-1, with no other port addressing that range.
REQ-013 SHALL keep, per port, a write pointer, a frame-start pointer, an open-frame flag, an overflow flag and an occupancy counter (OW bits).
REQ-014 SHALL treat an accepted beat (i_wr_en, i_abort[port]=0, frame open or i_sof=1, occupancy < pREGION_DEPTH) as one that writes i_data at the port write pointer on the next clock edge (1-cycle write latency), increments occupancy and advances the pointer.
REQ-015 SHALL wrap the write pointer from (p+1)*pREGION_DEPTH-1 back to p*pREGION_DEPTH.
REQ-016 SHALL, on i_sof, latch the current write pointer as frame start and set the open flag; i_sof while a frame is open implicitly aborts the old frame (REQ-019) and starts the new frame at the rolled-back pointer.
REQ-017 SHALL, on an accepted i_eof beat, the cycle after that beat, assert o_desc_valid for exactly one cycle with the port, start, the address of the last word and i_extra_byte, then clear the open flag; i_sof and i_eof on one beat form a one-word frame with start == end.
REQ-018 SHALL, on a beat arriving with occupancy == pREGION_DEPTH, set the overflow flag and not write; at that frame's EOF it SHALL roll back and pulse o_drop[port] instead of emitting a descriptor.
REQ-019 SHALL implement rollback as: write pointer := frame start, occupancy -= words written by the open frame, open and overflow flags cleared.
REQ-020 SHALL apply i_abort[p] as a rollback of port p; when i_abort[p] is high the same-cycle beat for port p is discarded; with no open frame, i_abort is a no-op.
REQ-021 SHALL silently discard, with no state change, any beat without i_sof on a port with no open frame.
REQ-022 SHALL subtract i_free_words from the occupancy of port i_free_port, saturating at 0; a free and a write/rollback on the same port in one cycle combine arithmetically in one update.
REQ-023 SHALL register i_rd_addr when i_rd_en is high and present o_rd_data 2 cycles after i_rd_en; o_rd_data holds its value when i_rd_en is low.
REQ-024 SHALL emit at most one descriptor per cycle (only one port writes per cycle), and SHALL pulse o_drop only for the port concerned.
REQ-025 SHALL drive o_full combinationally from the occupancy counters.

Reset
REQ-026 SHALL, while i_reset is high at a clock edge, set each write pointer and frame start to p*pREGION_DEPTH, clear all flags and occupancies, and drive o_desc_valid=0, o_drop=0, o_desc_*=0, o_rd_data=0.
REQ-027 SHALL discard a frame open at reset with no descriptor and no drop pulse; RAM contents are not cleared.

Verification
REQ-028 SHALL cover: port 1, 4-beat frame (sof on beat 1, eof with extra=2'b10 on beat 4) -> one o_desc_valid, port=1, start=1536, end=1539, extra=2.
REQ-029 SHALL cover: port 0, pointer at 1534, 3-word frame -> writes to 1534, 1535, 0; descriptor start=1534, end=0.
REQ-030 SHALL cover: port 2 fills its region (occupancy 1536), then a new frame of 5 beats -> o_full[2]=1, no writes, o_drop=3'b100 for one cycle after eof, pointer unchanged.
REQ-031 SHALL cover: port 3 open frame of 10 words, i_abort[3]=1 together with beat 11 -> beat discarded, occupancy back to its pre-frame value, next sof starts at the old frame start.
REQ-032 SHALL cover: in one cycle, free 4 words on port 0 plus an accepted write on port 0 -> occupancy net -3; free 10 with occupancy 6 -> occupancy 0.
REQ-033 SHALL cover: read of address 1537 after REQ-028 -> o_rd_data equals beat 2 exactly 2 cycles after i_rd_en.

Source files
------------

// File: rtl/pkt_mem_nport_if.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_mem_nport_if
//  Brief    : Bus bundle for the N-port packet memory: write beats, aborts,
//             occupancy release, read port, descriptor and status outputs.
//             Signal directions are named from the memory's point of view.
//  Revision : 1.0 - initial release
// ============================================================================
interface pkt_mem_nport_if #(
    parameter int pPORTS        = 4,
    parameter int pDATA_WIDTH   = 32,
    parameter int pREGION_DEPTH = 1536
);
    localparam int c_AW = $clog2(pPORTS * pREGION_DEPTH);
    localparam int c_PW = $clog2(pPORTS);
    localparam int c_OW = $clog2(pREGION_DEPTH + 1);

    // Write side
    logic                   i_wr_en;
    logic [c_PW-1:0]        i_port_num;
    logic [pDATA_WIDTH-1:0] i_data;
    logic                   i_sof;
    logic                   i_eof;
    logic [1:0]             i_extra_byte;
    logic [pPORTS-1:0]      i_abort;
    // Release side
    logic                   i_free_en;
    logic [c_PW-1:0]        i_free_port;
    logic [c_OW-1:0]        i_free_words;
    // Read side
    logic                   i_rd_en;
    logic [c_AW-1:0]        i_rd_addr;
    logic [pDATA_WIDTH-1:0] o_rd_data;
    // Descriptor / status
    logic                   o_desc_valid;
    logic [c_PW-1:0]        o_desc_port;
    logic [c_AW-1:0]        o_desc_start;
    logic [c_AW-1:0]        o_desc_end;
    logic [1:0]             o_desc_extra;
    logic [pPORTS-1:0]      o_drop;
    logic [pPORTS-1:0]      o_full;

    modport slave (
        input  i_wr_en, i_port_num, i_data, i_sof, i_eof, i_extra_byte, i_abort,
        input  i_free_en, i_free_port, i_free_words, i_rd_en, i_rd_addr,
        output o_rd_data, o_desc_valid, o_desc_port, o_desc_start, o_desc_end,
        output o_desc_extra, o_drop, o_full
    );

    modport master (
        output i_wr_en, i_port_num, i_data, i_sof, i_eof, i_extra_byte, i_abort,
        output i_free_en, i_free_port, i_free_words, i_rd_en, i_rd_addr,
        input  o_rd_data, o_desc_valid, o_desc_port, o_desc_start, o_desc_end,
        input  o_desc_extra, o_drop, o_full
    );
endinterface
`default_nettype wire

// File: rtl/pkt_mem_nport.sv
`default_nettype none
// ============================================================================
//  Module   : pkt_mem_nport
//  Brief    : Shared packet RAM split into one circular region per ingress
//             port. Tracks open frames per port, emits a descriptor on good
//             EOF, rolls back on abort/overflow and supports word release.
//  Revision : 1.0 - initial release
// ============================================================================
module pkt_mem_nport #(
    parameter int pPORTS        = 4,
    parameter int pDATA_WIDTH   = 32,
    parameter int pREGION_DEPTH = 1536
) (
    input  wire logic        i_clk,
    input  wire logic        i_reset,
    pkt_mem_nport_if.slave   bus
);
    localparam int c_AW    = $clog2(pPORTS * pREGION_DEPTH);
    localparam int c_PW    = $clog2(pPORTS);
    localparam int c_OW    = $clog2(pREGION_DEPTH + 1);
    localparam int c_WORDS = pPORTS * pREGION_DEPTH;

    logic [pDATA_WIDTH-1:0] r_mem [c_WORDS];

    // Per-port results gathered for the shared RAM / descriptor path
    logic [pPORTS-1:0] w_we;
    logic [pPORTS-1:0] w_fire;
    logic [pPORTS-1:0] w_drop;
    logic [pPORTS-1:0] w_full;
    logic [c_AW-1:0]   w_addr_p  [pPORTS];
    logic [c_AW-1:0]   w_start_p [pPORTS];

    for (genvar p = 0; p < pPORTS; p++) begin : g_port
        localparam logic [c_AW-1:0] c_BASE  = c_AW'(p * pREGION_DEPTH);
        localparam logic [c_AW-1:0] c_LAST  = c_AW'((p + 1) * pREGION_DEPTH - 1);
        localparam logic [c_OW-1:0] c_DEPTH = c_OW'(pREGION_DEPTH);
        localparam logic [c_PW-1:0] c_ID    = c_PW'(p);

        logic [c_AW-1:0] r_wr_ptr, r_start;
        logic            r_open, r_ovf;
        logic [c_OW-1:0] r_occ, r_cnt;

        logic            w_sel, w_roll_abort, w_beat, w_roll, w_room, w_wr;
        logic            w_eff_ovf, w_eof_ok, w_eof_drop, w_free_hit;
        logic [c_AW-1:0] w_eff_ptr, w_eff_start, w_ptr_a;
        logic [c_OW-1:0] w_eff_occ, w_eff_cnt, w_occ_a, w_cnt_a, w_occ_pre, w_occ_nxt;

        assign w_sel        = bus.i_wr_en && (bus.i_port_num == c_ID);
        assign w_roll_abort = bus.i_abort[p] && r_open;
        // A beat belongs to a frame if it opens one or continues one
        assign w_beat       = w_sel && !bus.i_abort[p] && (r_open || bus.i_sof);
        // SOF on an open frame throws the old frame away before starting anew
        assign w_roll       = w_roll_abort || (w_beat && bus.i_sof && r_open);

        assign w_eff_ptr    = w_roll ? r_start : r_wr_ptr;
        assign w_eff_occ    = w_roll ? (r_occ - r_cnt) : r_occ;
        assign w_eff_start  = bus.i_sof ? w_eff_ptr : r_start;
        assign w_eff_cnt    = bus.i_sof ? '0 : r_cnt;
        assign w_room       = (w_eff_occ < c_DEPTH);
        assign w_wr         = w_beat && w_room;
        assign w_eff_ovf    = (bus.i_sof ? 1'b0 : r_ovf) | (w_beat & ~w_room);
        assign w_eof_ok     = w_beat && bus.i_eof && !w_eff_ovf;
        assign w_eof_drop   = w_beat && bus.i_eof &&  w_eff_ovf;

        assign w_ptr_a      = !w_wr ? w_eff_ptr :
                              (w_eff_ptr == c_LAST) ? c_BASE : (w_eff_ptr + c_AW'(1));
        assign w_occ_a      = w_eff_occ + c_OW'(w_wr);
        assign w_cnt_a      = w_eff_cnt + c_OW'(w_wr);

        // Occupancy after write / rollback, before release is applied
        assign w_occ_pre    = w_eof_drop   ? (w_occ_a - w_cnt_a) :
                              w_beat       ? w_occ_a :
                              w_roll_abort ? (r_occ - r_cnt) : r_occ;
        assign w_free_hit   = bus.i_free_en && (bus.i_free_port == c_ID);
        assign w_occ_nxt    = !w_free_hit ? w_occ_pre :
                              (w_occ_pre > bus.i_free_words) ? (w_occ_pre - bus.i_free_words) : '0;

        // Per-port frame bookkeeping
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                r_wr_ptr <= c_BASE;
                r_start  <= c_BASE;
                r_open   <= 1'b0;
                r_ovf    <= 1'b0;
                r_occ    <= '0;
                r_cnt    <= '0;
            end else begin
                r_occ <= w_occ_nxt;
                if (w_beat) begin
                    r_start <= w_eff_start;
                    if (bus.i_eof) begin
                        r_wr_ptr <= w_eof_drop ? w_eff_start : w_ptr_a;
                        r_open   <= 1'b0;
                        r_ovf    <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_wr_ptr <= w_ptr_a;
                        r_open   <= 1'b1;
                        r_ovf    <= w_eff_ovf;
                        r_cnt    <= w_cnt_a;
                    end
                end else if (w_roll_abort) begin
                    r_wr_ptr <= r_start;
                    r_open   <= 1'b0;
                    r_ovf    <= 1'b0;
                    r_cnt    <= '0;
                end
            end
        end

        assign w_we[p]      = w_wr;
        assign w_fire[p]    = w_eof_ok;
        assign w_drop[p]    = w_eof_drop;
        assign w_full[p]    = (r_occ == c_DEPTH);
        assign w_addr_p[p]  = w_eff_ptr;
        assign w_start_p[p] = w_eff_start;
    end

    logic                   w_mem_we, w_desc_fire;
    logic [c_AW-1:0]        w_mem_addr, w_desc_start;

    // Only one port can be addressed per cycle, so a simple select suffices
    always_comb begin
        w_mem_we     = 1'b0;
        w_mem_addr   = '0;
        w_desc_fire  = 1'b0;
        w_desc_start = '0;
        for (int p = 0; p < pPORTS; p++) begin
            if (w_we[p]) begin
                w_mem_we   = 1'b1;
                w_mem_addr = w_addr_p[p];
            end
            if (w_fire[p]) begin
                w_desc_fire  = 1'b1;
                w_desc_start = w_start_p[p];
            end
        end
    end

    // Packet RAM write port; contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= bus.i_data;
    end

    logic [c_AW-1:0]        r_rd_addr;
    logic                   r_rd_pend;
    logic [pDATA_WIDTH-1:0] r_rd_data;

    // Two-stage read: capture address, then fetch into a holding register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_addr <= '0;
            r_rd_pend <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_rd_pend <= bus.i_rd_en;
            if (bus.i_rd_en) r_rd_addr <= bus.i_rd_addr;
            if (r_rd_pend)   r_rd_data <= r_mem[r_rd_addr];
        end
    end

    logic                   r_desc_valid;
    logic [c_PW-1:0]        r_desc_port;
    logic [c_AW-1:0]        r_desc_start, r_desc_end;
    logic [1:0]             r_desc_extra;
    logic [pPORTS-1:0]      r_drop;

    // Descriptor and drop pulses, one cycle after the closing beat
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_desc_valid <= 1'b0;
            r_desc_port  <= '0;
            r_desc_start <= '0;
            r_desc_end   <= '0;
            r_desc_extra <= '0;
            r_drop       <= '0;
        end else begin
            r_desc_valid <= w_desc_fire;
            r_drop       <= w_drop;
            if (w_desc_fire) begin
                r_desc_port  <= bus.i_port_num;
                r_desc_start <= w_desc_start;
                r_desc_end   <= w_mem_addr;
                r_desc_extra <= bus.i_extra_byte;
            end
        end
    end

    assign bus.o_rd_data    = r_rd_data;
    assign bus.o_desc_valid = r_desc_valid;
    assign bus.o_desc_port  = r_desc_port;
    assign bus.o_desc_start = r_desc_start;
    assign bus.o_desc_end   = r_desc_end;
    assign bus.o_desc_extra = r_desc_extra;
    assign bus.o_drop       = r_drop;
    assign bus.o_full       = w_full;
endmodule
`default_nettype wire

// File: tb/tb_pkt_mem_nport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pkt_mem_nport
//  Brief    : Directed self-checking bench for pkt_mem_nport (4 ports,
//             1536 words per region, 32-bit data).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pkt_mem_nport;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    pkt_mem_nport_if #(.pPORTS(4), .pDATA_WIDTH(32), .pREGION_DEPTH(1536)) bus ();

    pkt_mem_nport #(.pPORTS(4), .pDATA_WIDTH(32), .pREGION_DEPTH(1536)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // n consecutive beats on one port; optional SOF on first and EOF on last
    task automatic run(input int port, input int n, input logic [31:0] d0,
                       input bit sof_first, input bit eof_last);
        for (int i = 0; i < n; i++) begin
            bus.i_wr_en      = 1'b1;
            bus.i_port_num   = 2'(port);
            bus.i_data       = d0 + 32'(i);
            bus.i_sof        = sof_first && (i == 0);
            bus.i_eof        = eof_last && (i == n - 1);
            tick();
        end
        bus.i_wr_en = 1'b0;
        bus.i_sof   = 1'b0;
        bus.i_eof   = 1'b0;
    endtask

    task automatic release_words(input int port, input int n);
        bus.i_free_en    = 1'b1;
        bus.i_free_port  = 2'(port);
        bus.i_free_words = 11'(n);
        tick();
        bus.i_free_en    = 1'b0;
    endtask

    task automatic read_word(input int addr);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = 13'(addr);
        tick();
        bus.i_rd_en   = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_wr_en = 0; bus.i_port_num = 0; bus.i_data = 0; bus.i_sof = 0;
        bus.i_eof = 0; bus.i_extra_byte = 0; bus.i_abort = 0; bus.i_free_en = 0;
        bus.i_free_port = 0; bus.i_free_words = 0; bus.i_rd_en = 0; bus.i_rd_addr = 0;

        // Reset state
        tick(); tick();
        rst = 1'b0;
        chk("rst_desc_valid", 64'(bus.o_desc_valid), 64'd0);
        chk("rst_desc_start", 64'(bus.o_desc_start), 64'd0);
        chk("rst_drop",       64'(bus.o_drop),       64'd0);
        chk("rst_full",       64'(bus.o_full),       64'd0);
        chk("rst_rd_data",    64'(bus.o_rd_data),    64'd0);

        // Port 1, 4-beat frame, extra=2
        bus.i_extra_byte = 2'b10;
        run(1, 4, 32'hA000_0000, 1, 1);
        chk("p1_desc_valid", 64'(bus.o_desc_valid), 64'd1);
        chk("p1_desc_port",  64'(bus.o_desc_port),  64'd1);
        chk("p1_desc_start", 64'(bus.o_desc_start), 64'd1536);
        chk("p1_desc_end",   64'(bus.o_desc_end),   64'd1539);
        chk("p1_desc_extra", 64'(bus.o_desc_extra), 64'd2);
        bus.i_extra_byte = 2'b00;
        tick();
        chk("p1_desc_one_cycle", 64'(bus.o_desc_valid), 64'd0);

        // Read 1537 -> beat 2, present two cycles after i_rd_en
        bus.i_rd_en = 1'b1; bus.i_rd_addr = 13'd1537;
        tick();
        bus.i_rd_en = 1'b0;
        chk("rd_not_yet", 64'(bus.o_rd_data), 64'd0);
        tick();
        chk("rd_1537", 64'(bus.o_rd_data), 64'hA000_0001);
        tick();
        chk("rd_hold", 64'(bus.o_rd_data), 64'hA000_0001);

        // Port 0: move pointer to 1534, then a wrapping 3-word frame
        run(0, 1534, 32'hB000_0000, 1, 1);
        chk("p0_big_end", 64'(bus.o_desc_end), 64'd1533);
        release_words(0, 1534);
        run(0, 3, 32'hC000_0000, 1, 1);
        chk("p0_wrap_valid", 64'(bus.o_desc_valid), 64'd1);
        chk("p0_wrap_start", 64'(bus.o_desc_start), 64'd1534);
        chk("p0_wrap_end",   64'(bus.o_desc_end),   64'd0);
        read_word(0);
        chk("rd_wrap_0", 64'(bus.o_rd_data), 64'hC000_0002);
        read_word(1535);
        chk("rd_wrap_1535", 64'(bus.o_rd_data), 64'hC000_0001);

        // Port 0: occupancy 3 -> 13, then free 4 together with an accepted SOF beat
        run(0, 10, 32'hD000_0000, 1, 1);
        chk("p0_f2_start", 64'(bus.o_desc_start), 64'd1);
        bus.i_free_en = 1'b1; bus.i_free_port = 2'd0; bus.i_free_words = 11'd4;
        bus.i_wr_en = 1'b1; bus.i_port_num = 2'd0; bus.i_data = 32'hE000_0000; bus.i_sof = 1'b1;
        tick();
        bus.i_free_en = 1'b0; bus.i_wr_en = 1'b0; bus.i_sof = 1'b0;
        // occupancy now 10: 1525 more beats reach 1535, the EOF beat reaches 1536
        run(0, 1525, 32'hE000_0001, 0, 0);
        chk("p0_net_not_full", 64'(bus.o_full[0]), 64'd0);
        run(0, 1, 32'hE000_05F6, 0, 1);
        chk("p0_net_full",  64'(bus.o_full[0]),     64'd1);
        chk("p0_net_desc",  64'(bus.o_desc_valid),  64'd1);
        chk("p0_net_start", 64'(bus.o_desc_start),  64'd11);
        chk("p0_net_end",   64'(bus.o_desc_end),    64'd1);

        // Saturating release: 1536 -> 6 -> free 10 -> 0, then a full-region frame fits
        release_words(0, 1530);
        release_words(0, 10);
        run(0, 1535, 32'hF000_0000, 1, 0);
        chk("p0_sat_not_full", 64'(bus.o_full[0]), 64'd0);
        run(0, 1, 32'hF000_05FF, 0, 1);
        chk("p0_sat_desc", 64'(bus.o_desc_valid), 64'd1);
        chk("p0_sat_full", 64'(bus.o_full[0]),    64'd1);
        chk("p0_sat_drop", 64'(bus.o_drop),       64'd0);
        release_words(0, 1536);
        chk("p0_released", 64'(bus.o_full[0]), 64'd0);

        // Port 2: fill region, then a 5-beat frame must be dropped
        run(2, 1536, 32'h2200_0000, 1, 1);
        chk("p2_fill_end",  64'(bus.o_desc_end), 64'd4607);
        chk("p2_full",      64'(bus.o_full),     64'b0100);
        run(2, 4, 32'h2F00_0000, 1, 0);
        chk("p2_ovf_no_drop_yet", 64'(bus.o_drop), 64'd0);
        run(2, 1, 32'h2F00_0004, 0, 1);
        chk("p2_drop",       64'(bus.o_drop),       64'b0100);
        chk("p2_drop_nodesc", 64'(bus.o_desc_valid), 64'd0);
        chk("p2_still_full", 64'(bus.o_full[2]),    64'd1);
        tick();
        chk("p2_drop_one_cycle", 64'(bus.o_drop), 64'd0);
        read_word(3072);
        chk("p2_no_write", 64'(bus.o_rd_data), 64'h2200_0000);
        release_words(2, 1536);
        run(2, 1, 32'h2300_0000, 1, 1);
        chk("p2_ptr_start", 64'(bus.o_desc_start), 64'd3072);
        chk("p2_ptr_end",   64'(bus.o_desc_end),   64'd3072);

        // Port 3: abort an open 10-word frame with beat 11
        run(3, 2, 32'h3300_0000, 1, 1);
        run(3, 10, 32'h3400_0000, 1, 0);
        bus.i_abort = 4'b1000;
        bus.i_wr_en = 1'b1; bus.i_port_num = 2'd3; bus.i_data = 32'h3400_000A; bus.i_eof = 1'b1;
        tick();
        bus.i_abort = 4'b0000; bus.i_wr_en = 1'b0; bus.i_eof = 1'b0;
        chk("p3_abort_nodesc", 64'(bus.o_desc_valid), 64'd0);
        chk("p3_abort_nodrop", 64'(bus.o_drop),       64'd0);
        run(3, 1, 32'h3500_0000, 1, 1);
        chk("p3_restart_start", 64'(bus.o_desc_start), 64'd4610);
        // occupancy should be 3: 1533 more words fill exactly
        run(3, 1532, 32'h3600_0000, 1, 0);
        chk("p3_occ_not_full", 64'(bus.o_full[3]), 64'd0);
        run(3, 1, 32'h3600_05FC, 0, 1);
        chk("p3_occ_full", 64'(bus.o_full[3]),    64'd1);
        chk("p3_occ_desc", 64'(bus.o_desc_valid), 64'd1);

        // Port 1: beats without SOF on an idle port are ignored
        run(1, 2, 32'h1100_0000, 0, 0);
        run(1, 1, 32'h1200_0000, 1, 1);
        chk("p1_nosof_start", 64'(bus.o_desc_start), 64'd1540);

        // Reset with an open frame: no descriptor, no drop, pointers back to base
        run(1, 2, 32'h1300_0000, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_desc", 64'(bus.o_desc_valid), 64'd0);
        chk("rst2_drop", 64'(bus.o_drop),       64'd0);
        chk("rst2_full", 64'(bus.o_full),       64'd0);
        chk("rst2_rd",   64'(bus.o_rd_data),    64'd0);
        tick();
        chk("rst2_desc_later", 64'(bus.o_desc_valid), 64'd0);
        run(1, 1, 32'h1400_0000, 1, 1);
        chk("rst2_p1_start", 64'(bus.o_desc_start), 64'd1536);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
